// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared encodings for the multi-cycle MIPS core: opcode/funct constants,
// controller state codes, datapath mux selects and ALU operations. The
// datapath decodes the same values, so they must change together.
// Also provides the instruction-class type produced by mips_mc_decode and a
// helper that maps a class onto its ALU control bundle.
// -----------------------------------------------------------------------------
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // Controller states (exported on the debug port)
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_MD     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  // Next-PC select
  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JIDX = 2'd2;
  localparam logic [1:0] NPC_JR   = 2'd3;

  // GRF destination select
  localparam logic [1:0] DST_RT   = 2'd0;
  localparam logic [1:0] DST_RD   = 2'd1;
  localparam logic [1:0] DST_RA   = 2'd2;

  // GRF write-data select
  localparam logic [1:0] WD_ALU   = 2'd0;
  localparam logic [1:0] WD_DM    = 2'd1;
  localparam logic [1:0] WD_PC4   = 2'd2;
  localparam logic [1:0] WD_HILO  = 2'd3;

  // ALU operations
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_OR   = 4'd2;
  localparam logic [3:0] ALU_LUI  = 4'd3;

  typedef enum logic [3:0] {
    C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ,
    C_J, C_JAL, C_JR, C_MULT, C_DIV, C_MFHI, C_MFLO, C_ILLEGAL
  } instr_class_e;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;   // 0 RD2, 1 extended immediate
    logic       ext_op;    // 0 zero-extend, 1 sign-extend
  } alu_ctrl_t;

  // ALU setup for a class; held unchanged from EXEC through WB so the ALU
  // result stays valid while it is written back.
  function automatic alu_ctrl_t alu_ctrl(input instr_class_e cls);
    alu_ctrl_t a;
    a = '0;
    case (cls)
      C_ADDU:     a = '{alu_op: ALU_ADD, alu_src: 1'b0, ext_op: 1'b0};
      C_SUBU:     a = '{alu_op: ALU_SUB, alu_src: 1'b0, ext_op: 1'b0};
      C_ORI:      a = '{alu_op: ALU_OR,  alu_src: 1'b1, ext_op: 1'b0};
      C_LUI:      a = '{alu_op: ALU_LUI, alu_src: 1'b1, ext_op: 1'b0};
      C_LW, C_SW: a = '{alu_op: ALU_ADD, alu_src: 1'b1, ext_op: 1'b1};
      C_BEQ:      a = '{alu_op: ALU_SUB, alu_src: 1'b0, ext_op: 1'b1};
      default:    a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/mips_mc_decode.sv
// -----------------------------------------------------------------------------
// mips_mc_decode
// Combinational instruction classifier for the multi-cycle controller.
//   i_instr   [31:0]  IR contents
//   o_class           instruction class (C_ILLEGAL when unsupported)
//   o_illegal         unsupported opcode or R-type funct
// Only opcode and funct select the class; register and immediate fields are
// consumed by the datapath, not here.
// -----------------------------------------------------------------------------
module mips_mc_decode
  import mips_pkg::*;
(
  input  logic [31:0]  i_instr,
  output instr_class_e o_class,
  output logic         o_illegal
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic       w_unused_fields;

  assign w_op = i_instr[31:26];
  assign w_fn = i_instr[5:0];
  assign w_unused_fields = ^i_instr[25:6];

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    o_class = C_ILLEGAL;
    case (w_op)
      OP_RTYPE: begin
        case (w_fn)
          FN_ADDU: o_class = C_ADDU;
          FN_SUBU: o_class = C_SUBU;
          FN_JR:   o_class = C_JR;
          FN_MULT: o_class = C_MULT;
          FN_DIV:  o_class = C_DIV;
          FN_MFHI: o_class = C_MFHI;
          FN_MFLO: o_class = C_MFLO;
          default: o_class = C_ILLEGAL;
        endcase
      end
      OP_J:    o_class = C_J;
      OP_JAL:  o_class = C_JAL;
      OP_BEQ:  o_class = C_BEQ;
      OP_ORI:  o_class = C_ORI;
      OP_LUI:  o_class = C_LUI;
      OP_LW:   o_class = C_LW;
      OP_SW:   o_class = C_SW;
      default: o_class = C_ILLEGAL;
    endcase
  end

  assign o_illegal = (o_class == C_ILLEGAL);

endmodule

// File: rtl/mips_mc_ctrl.sv
// -----------------------------------------------------------------------------
// mips_mc_ctrl
// Multi-cycle control FSM: FETCH -> DECODE -> EXEC -> MEM -> WB, plus an
// MD state for mult/div and a terminal HALT state.
// Inputs : i_clk, i_reset (sync, active-high), i_instr (IR), i_zero,
//          i_imem_rdy, i_dmem_rdy
// Outputs: memory requests (o_imem_req, o_dmem_req, o_dmem_we), register
//          enables (o_ir_we, o_pc_we, o_reg_we), mux selects (o_npc_sel,
//          o_reg_dst, o_wd_sel, o_hilo_sel), ALU controls (o_alu_op,
//          o_alu_src, o_ext_op), MD unit (o_md_start, o_md_op), sticky
//          o_fault and debug o_state.
// All control outputs are combinational from state, IR and the ready/zero
// inputs; only state, the MD countdown, the memory wait counter and fault
// are registered.
// -----------------------------------------------------------------------------
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int MUL_CYCLES  = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int MEM_TIMEOUT = 16
)(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_instr,
  input  logic        i_zero,
  input  logic        i_imem_rdy,
  input  logic        i_dmem_rdy,
  output logic        o_imem_req,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic        o_ir_we,
  output logic        o_pc_we,
  output logic [1:0]  o_npc_sel,
  output logic        o_reg_we,
  output logic [1:0]  o_reg_dst,
  output logic [1:0]  o_wd_sel,
  output logic        o_hilo_sel,
  output logic [3:0]  o_alu_op,
  output logic        o_alu_src,
  output logic        o_ext_op,
  output logic        o_md_start,
  output logic        o_md_op,
  output logic        o_fault,
  output logic [2:0]  o_state
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  // Wait count seen in the cycle that would be the MEM_TIMEOUT-th without rdy
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;
  // Countdown starts at N-1 so that the MD state lasts exactly N cycles
  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  logic [2:0]        r_state;
  logic [5:0]        r_md_cnt;
  logic [WAIT_W-1:0] r_wait;
  logic              r_fault;

  logic [2:0]        w_next;
  logic              w_fault_set;
  logic              w_waiting;
  logic              w_timeout;
  instr_class_e      w_class;
  logic              w_illegal;
  alu_ctrl_t         w_alu;

  mips_mc_decode u_decode (
    .i_instr   (i_instr),
    .o_class   (w_class),
    .o_illegal (w_illegal)
  );

  assign w_alu = alu_ctrl(w_class);

  // A cycle counts as waiting only in the state that owns the handshake
  assign w_waiting = ((r_state == S_FETCH) && !i_imem_rdy) ||
                     ((r_state == S_MEM)   && !i_dmem_rdy);
  // Checked only on the no-rdy branches, so a same-cycle rdy always wins
  assign w_timeout = (MEM_TIMEOUT > 0) && w_waiting && (r_wait == WAIT_LAST);

  always_comb begin
    w_next      = r_state;
    w_fault_set = 1'b0;
    o_imem_req  = 1'b0;
    o_dmem_req  = 1'b0;
    o_dmem_we   = 1'b0;
    o_ir_we     = 1'b0;
    o_pc_we     = 1'b0;
    o_npc_sel   = NPC_PC4;
    o_reg_we    = 1'b0;
    o_reg_dst   = DST_RT;
    o_wd_sel    = WD_ALU;
    o_hilo_sel  = 1'b0;
    o_alu_op    = ALU_ADD;
    o_alu_src   = 1'b0;
    o_ext_op    = 1'b0;
    o_md_start  = 1'b0;
    o_md_op     = 1'b0;

    case (r_state)
      S_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_rdy) begin
          o_ir_we   = 1'b1;
          o_pc_we   = 1'b1;
          o_npc_sel = NPC_PC4;
          w_next    = S_DECODE;
        end else if (w_timeout) begin
          w_fault_set = 1'b1;
          w_next      = S_HALT;
        end
      end

      S_DECODE: begin
        if (w_illegal) begin
          w_fault_set = 1'b1;
          w_next      = S_HALT;
        end else begin
          case (w_class)
            C_J: begin
              o_pc_we   = 1'b1;
              o_npc_sel = NPC_JIDX;
              w_next    = S_FETCH;
            end
            C_JAL: begin
              // PC already holds PC+4 from FETCH, so the link value is ready
              o_pc_we   = 1'b1;
              o_npc_sel = NPC_JIDX;
              o_reg_we  = 1'b1;
              o_reg_dst = DST_RA;
              o_wd_sel  = WD_PC4;
              w_next    = S_FETCH;
            end
            C_JR: begin
              o_pc_we   = 1'b1;
              o_npc_sel = NPC_JR;
              w_next    = S_FETCH;
            end
            C_MULT, C_DIV: begin
              o_md_start = 1'b1;
              o_md_op    = (w_class == C_DIV);
              w_next     = S_MD;
            end
            default: w_next = S_EXEC;
          endcase
        end
      end

      S_EXEC: begin
        {o_alu_op, o_alu_src, o_ext_op} = w_alu;
        case (w_class)
          C_BEQ: begin
            o_pc_we   = i_zero;
            o_npc_sel = NPC_BR;
            w_next    = S_FETCH;
          end
          C_LW, C_SW: w_next = S_MEM;
          default:    w_next = S_WB;
        endcase
      end

      S_MEM: begin
        {o_alu_op, o_alu_src, o_ext_op} = w_alu;
        o_dmem_req = 1'b1;
        o_dmem_we  = (w_class == C_SW);
        if (i_dmem_rdy) begin
          w_next = (w_class == C_SW) ? S_FETCH : S_WB;
        end else if (w_timeout) begin
          w_fault_set = 1'b1;
          w_next      = S_HALT;
        end
      end

      S_WB: begin
        {o_alu_op, o_alu_src, o_ext_op} = w_alu;
        o_reg_we = 1'b1;
        w_next   = S_FETCH;
        case (w_class)
          C_LW: begin
            o_reg_dst = DST_RT;
            o_wd_sel  = WD_DM;
          end
          C_ORI, C_LUI: begin
            o_reg_dst = DST_RT;
            o_wd_sel  = WD_ALU;
          end
          C_MFHI, C_MFLO: begin
            o_reg_dst  = DST_RD;
            o_wd_sel   = WD_HILO;
            o_hilo_sel = (w_class == C_MFHI);
          end
          default: begin
            o_reg_dst = DST_RD;
            o_wd_sel  = WD_ALU;
          end
        endcase
      end

      S_MD: begin
        o_md_op = (w_class == C_DIV);
        if (r_md_cnt == 6'd0) w_next = S_FETCH;
      end

      S_HALT: w_next = S_HALT;

      default: w_next = S_FETCH;
    endcase

    // Reset cycle: nothing may write architectural state, whatever the FSM
    // happens to be doing.
    if (i_reset) begin
      o_imem_req = 1'b0;
      o_dmem_req = 1'b0;
      o_dmem_we  = 1'b0;
      o_ir_we    = 1'b0;
      o_pc_we    = 1'b0;
      o_reg_we   = 1'b0;
      o_md_start = 1'b0;
      o_npc_sel  = NPC_PC4;
      o_reg_dst  = DST_RT;
      o_wd_sel   = WD_ALU;
      o_hilo_sel = 1'b0;
      o_alu_op   = ALU_ADD;
      o_alu_src  = 1'b0;
      o_ext_op   = 1'b0;
      o_md_op    = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order races.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_FETCH;
      r_md_cnt <= 6'd0;
      r_wait   <= '0;
      r_fault  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_fault_set) r_fault <= 1'b1;

      // Consecutive no-rdy cycles; cleared on rdy or on any state change
      if (w_waiting && (w_next == r_state)) r_wait <= r_wait + WAIT_W'(1);
      else                                  r_wait <= '0;

      if ((r_state == S_DECODE) && (w_next == S_MD))
        r_md_cnt <= (w_class == C_DIV) ? DIV_LOAD : MUL_LOAD;
      else if ((r_state == S_MD) && (r_md_cnt != 6'd0))
        r_md_cnt <= r_md_cnt - 6'd1;
    end
  end

  assign o_fault = r_fault;
  assign o_state = r_state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_mc_ctrl
// Self-checking bench for mips_mc_ctrl. For each instruction the bench
// builds the expected per-cycle control picture from the instruction's
// phase list (fetch waits, decode, exec, memory waits, writeback, MD cycles)
// and a compare process checks the DUT against it on the falling edge.
// Instruction lengths are also pinned against hand-computed cycle counts.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mips_mc_ctrl;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;
  localparam int TMO   = 16;

  localparam logic [31:0] I_ADDU = 32'h00221821;
  localparam logic [31:0] I_SUBU = 32'h00221823;
  localparam logic [31:0] I_ORI  = 32'h34221234;
  localparam logic [31:0] I_LUI  = 32'h3C021234;
  localparam logic [31:0] I_LW   = 32'h8C220004;
  localparam logic [31:0] I_SW   = 32'hAC220004;
  localparam logic [31:0] I_BEQ  = 32'h10220004;
  localparam logic [31:0] I_J    = 32'h08000100;
  localparam logic [31:0] I_JAL  = 32'h0C000100;
  localparam logic [31:0] I_JR   = 32'h03E00008;
  localparam logic [31:0] I_MULT = 32'h00220018;
  localparam logic [31:0] I_DIV  = 32'h0022001A;
  localparam logic [31:0] I_MFHI = 32'h00001810;
  localparam logic [31:0] I_MFLO = 32'h00001812;
  localparam logic [31:0] I_BADO = 32'hFC000000;
  localparam logic [31:0] I_BADF = 32'h0000003F;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic [31:0] instr    = '0;
  logic        zero     = 1'b0;
  logic        imem_rdy = 1'b0;
  logic        dmem_rdy = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we;
  logic [1:0]  npc_sel, reg_dst, wd_sel;
  logic        hilo_sel, alu_src, ext_op, md_start, md_op, fault;
  logic [3:0]  alu_op;
  logic [2:0]  state;

  always #5 clk = ~clk;

  mips_mc_ctrl #(
    .MUL_CYCLES (MUL_N),
    .DIV_CYCLES (DIV_N),
    .MEM_TIMEOUT(TMO)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_instr    (instr),
    .i_zero     (zero),
    .i_imem_rdy (imem_rdy),
    .i_dmem_rdy (dmem_rdy),
    .o_imem_req (imem_req),
    .o_dmem_req (dmem_req),
    .o_dmem_we  (dmem_we),
    .o_ir_we    (ir_we),
    .o_pc_we    (pc_we),
    .o_npc_sel  (npc_sel),
    .o_reg_we   (reg_we),
    .o_reg_dst  (reg_dst),
    .o_wd_sel   (wd_sel),
    .o_hilo_sel (hilo_sel),
    .o_alu_op   (alu_op),
    .o_alu_src  (alu_src),
    .o_ext_op   (ext_op),
    .o_md_start (md_start),
    .o_md_op    (md_op),
    .o_fault    (fault),
    .o_state    (state)
  );

  typedef enum {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL,
                K_JR, K_MULT, K_DIV, K_MFHI, K_MFLO, K_BAD} kind_e;

  // Expected control picture for one cycle; c_* flags mark fields that
  // matter in that cycle.
  typedef struct packed {
    logic [2:0] st;
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we;
    logic [1:0] npc, dst, wd;
    logic       hilo;
    logic [3:0] aop;
    logic       asrc, ext, md_start, md_op, fault;
    logic       c_state, c_npc, c_hilo, c_aop, c_asrc, c_ext, c_mdop;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t cur;
  bit   cur_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, want);
    end
  endtask

  // Compare process: one expected picture per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (cur_valid) begin
      cur_valid = 1'b0;
      if (cur.c_state) begin
        check("state", state, cur.st);
        check("fault", fault, cur.fault);
      end
      check("imem_req", imem_req, cur.imem_req);
      check("dmem_req", dmem_req, cur.dmem_req);
      check("ir_we",    ir_we,    cur.ir_we);
      check("pc_we",    pc_we,    cur.pc_we);
      check("reg_we",   reg_we,   cur.reg_we);
      check("md_start", md_start, cur.md_start);
      if (cur.dmem_req) check("dmem_we", dmem_we, cur.dmem_we);
      if (cur.c_npc)    check("npc_sel", npc_sel, cur.npc);
      if (cur.reg_we) begin
        check("reg_dst", reg_dst, cur.dst);
        check("wd_sel",  wd_sel,  cur.wd);
      end
      if (cur.c_hilo) check("hilo_sel", hilo_sel, cur.hilo);
      if (cur.c_aop)  check("alu_op",   alu_op,   cur.aop);
      if (cur.c_asrc) check("alu_src",  alu_src,  cur.asrc);
      if (cur.c_ext)  check("ext_op",   ext_op,   cur.ext);
      if (cur.c_mdop) check("md_op",    md_op,    cur.md_op);
    end
  end

  function automatic exp_t blank(input logic [2:0] st);
    exp_t e;
    e = '0;
    e.st = st;
    e.c_state = 1'b1;
    return e;
  endfunction

  function automatic kind_e classify(input logic [31:0] ir);
    logic [5:0] op;
    logic [5:0] fn;
    op = ir[31:26];
    fn = ir[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h21:   return K_ADDU;
        6'h23:   return K_SUBU;
        6'h08:   return K_JR;
        6'h18:   return K_MULT;
        6'h1A:   return K_DIV;
        6'h10:   return K_MFHI;
        6'h12:   return K_MFLO;
        default: return K_BAD;
      endcase
    end
    case (op)
      6'h02:   return K_J;
      6'h03:   return K_JAL;
      6'h04:   return K_BEQ;
      6'h0D:   return K_ORI;
      6'h0F:   return K_LUI;
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      default: return K_BAD;
    endcase
  endfunction

  // ALU settings each instruction needs (add=0, sub=1, or=2, lui=3)
  function automatic exp_t with_alu(input exp_t e_in, input kind_e k);
    exp_t e;
    e = e_in;
    case (k)
      K_ADDU: begin e.aop = 4'd0; e.asrc = 1'b0; e.c_aop = 1'b1; e.c_asrc = 1'b1; end
      K_SUBU: begin e.aop = 4'd1; e.asrc = 1'b0; e.c_aop = 1'b1; e.c_asrc = 1'b1; end
      K_ORI:  begin e.aop = 4'd2; e.asrc = 1'b1; e.ext = 1'b0;
                    e.c_aop = 1'b1; e.c_asrc = 1'b1; e.c_ext = 1'b1; end
      K_LUI:  begin e.aop = 4'd3; e.asrc = 1'b1; e.ext = 1'b0;
                    e.c_aop = 1'b1; e.c_asrc = 1'b1; e.c_ext = 1'b1; end
      K_LW, K_SW: begin e.aop = 4'd0; e.asrc = 1'b1; e.ext = 1'b1;
                    e.c_aop = 1'b1; e.c_asrc = 1'b1; e.c_ext = 1'b1; end
      K_BEQ:  begin e.ext = 1'b1; e.c_ext = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  // Drive one cycle's inputs just after the rising edge and post its picture
  task automatic step(input logic rst, input logic [31:0] ir, input logic z,
                      input logic irdy, input logic drdy, input exp_t e);
    @(posedge clk);
    #1;
    reset    = rst;
    instr    = ir;
    zero     = z;
    imem_rdy = irdy;
    dmem_rdy = drdy;
    cur       = e;
    cur_valid = 1'b1;
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    e = '0;  // state not meaningful in the reset cycle; all enables low
    for (int i = 0; i < n; i++) step(1'b1, I_ADDU, 1'b0, 1'b1, 1'b1, e);
  endtask

  // Runs one instruction; rdy lines are held high in every state that does
  // not own them, so stray handshakes are exercised throughout.
  task automatic run_instr(input logic [31:0] ir, input int fwait,
                           input int dwait, input logic z, input int md_cut,
                           output int ncyc);
    kind_e k;
    exp_t  e;
    int    n_md;
    k    = classify(ir);
    ncyc = 0;

    for (int i = 0; i < fwait; i++) begin
      e = blank(3'd0); e.imem_req = 1'b1;
      step(1'b0, ir, z, 1'b0, 1'b1, e); ncyc++;
    end
    e = blank(3'd0); e.imem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
    e.npc = 2'd0; e.c_npc = 1'b1;
    step(1'b0, ir, z, 1'b1, 1'b1, e); ncyc++;

    e = blank(3'd1);
    case (k)
      K_J:   begin e.pc_we = 1'b1; e.npc = 2'd2; e.c_npc = 1'b1; end
      K_JAL: begin e.pc_we = 1'b1; e.npc = 2'd2; e.c_npc = 1'b1;
                   e.reg_we = 1'b1; e.dst = 2'd2; e.wd = 2'd2; end
      K_JR:  begin e.pc_we = 1'b1; e.npc = 2'd3; e.c_npc = 1'b1; end
      K_MULT, K_DIV: begin e.md_start = 1'b1; e.md_op = (k == K_DIV);
                   e.c_mdop = 1'b1; end
      default: ;
    endcase
    step(1'b0, ir, z, 1'b1, 1'b1, e); ncyc++;

    if (k inside {K_J, K_JAL, K_JR}) return;

    if (k == K_BAD) begin
      e = blank(3'd6); e.fault = 1'b1;
      step(1'b0, ir, z, 1'b1, 1'b1, e);
      step(1'b0, ir, z, 1'b1, 1'b1, e);
      return;
    end

    if (k == K_MULT || k == K_DIV) begin
      n_md = (k == K_DIV) ? DIV_N : MUL_N;
      if (md_cut > 0) n_md = md_cut;
      for (int i = 0; i < n_md; i++) begin
        e = blank(3'd5);
        step(1'b0, ir, z, 1'b1, 1'b1, e); ncyc++;
      end
      return;
    end

    e = with_alu(blank(3'd2), k);
    if (k == K_BEQ) begin
      e.pc_we = z; e.npc = 2'd1; e.c_npc = 1'b1;
      step(1'b0, ir, z, 1'b1, 1'b1, e); ncyc++;
      return;
    end
    step(1'b0, ir, z, 1'b1, 1'b1, e); ncyc++;

    if (k == K_LW || k == K_SW) begin
      e = blank(3'd3); e.dmem_req = 1'b1; e.dmem_we = (k == K_SW);
      for (int i = 0; i < dwait; i++) begin
        step(1'b0, ir, z, 1'b1, 1'b0, e); ncyc++;
      end
      step(1'b0, ir, z, 1'b1, 1'b1, e); ncyc++;
      if (k == K_SW) return;
    end

    e = with_alu(blank(3'd4), k);
    e.reg_we = 1'b1;
    case (k)
      K_LW:          begin e.dst = 2'd0; e.wd = 2'd1; end
      K_ORI, K_LUI:  begin e.dst = 2'd0; e.wd = 2'd0; end
      K_MFHI, K_MFLO: begin e.dst = 2'd1; e.wd = 2'd3;
                     e.hilo = (k == K_MFHI); e.c_hilo = 1'b1; end
      default:       begin e.dst = 2'd1; e.wd = 2'd0; end
    endcase
    step(1'b0, ir, z, 1'b1, 1'b1, e); ncyc++;
  endtask

  // imem never answers: TMO fetch cycles, then HALT with fault set
  task automatic fetch_timeout();
    exp_t e;
    for (int i = 0; i < TMO; i++) begin
      e = blank(3'd0); e.imem_req = 1'b1;
      step(1'b0, I_ADDU, 1'b0, 1'b0, 1'b1, e);
    end
    e = blank(3'd6); e.fault = 1'b1;
    step(1'b0, I_ADDU, 1'b0, 1'b1, 1'b1, e);
    step(1'b0, I_ADDU, 1'b0, 1'b1, 1'b1, e);
  endtask

  initial begin
    int n;
    do_reset(2);

    run_instr(I_ADDU, 0, 0, 1'b0, 0, n); check("len_addu",      n, 4);
    run_instr(I_LW,   0, 3, 1'b0, 0, n); check("len_lw_dwait3", n, 8);
    run_instr(I_BEQ,  0, 0, 1'b0, 0, n); check("len_beq_nt",    n, 3);
    run_instr(I_BEQ,  0, 0, 1'b1, 0, n); check("len_beq_t",     n, 3);
    run_instr(I_MULT, 0, 0, 1'b0, 0, n); check("len_mult",      n, 7);
    run_instr(I_MFLO, 0, 0, 1'b0, 0, n); check("len_mflo",      n, 4);
    run_instr(I_DIV,  0, 0, 1'b0, 0, n); check("len_div",       n, 12);
    run_instr(I_MFHI, 0, 0, 1'b0, 0, n);
    run_instr(I_SUBU, 0, 0, 1'b0, 0, n);
    run_instr(I_ORI,  2, 0, 1'b0, 0, n); check("len_ori_fwait2", n, 6);
    run_instr(I_LUI,  0, 0, 1'b0, 0, n);
    run_instr(I_SW,   0, 0, 1'b0, 0, n); check("len_sw",        n, 4);
    run_instr(I_J,    0, 0, 1'b0, 0, n); check("len_j",         n, 2);
    run_instr(I_JAL,  0, 0, 1'b0, 0, n); check("len_jal",       n, 2);
    run_instr(I_JR,   0, 0, 1'b0, 0, n);

    // rdy on the last cycle before expiry wins over the timeout
    run_instr(I_ADDU, TMO - 1, 0, 1'b0, 0, n);       check("len_fetch_edge", n, 19);
    run_instr(I_SW,   0, TMO - 1, 1'b0, 0, n);       check("len_mem_edge",   n, 19);
    run_instr(I_LW,   0, 0, 1'b0, 0, n);

    fetch_timeout();
    do_reset(1);

    run_instr(I_BADO, 0, 0, 1'b0, 0, n);
    do_reset(1);
    run_instr(I_BADF, 0, 0, 1'b0, 0, n);
    do_reset(1);

    // Reset in the middle of a multiply
    run_instr(I_MULT, 0, 0, 1'b0, 2, n);
    do_reset(1);
    run_instr(I_ADDU, 0, 0, 1'b0, 0, n); check("len_after_md_reset", n, 4);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
